branch_predictor: RTL and testbench

Dynamic branch predictor for the 5-stage pipelined RV32 core, replacing static not-taken with a parametrised direction table (BHT) and branch target buffer (BTB). IF looks up the current PC and gets a taken/target prediction in the same cycle. EX reports each resolved conditional branch (beq/bne/blt/bge). The block trains its tables from those reports, flags mispredictions, supplies the redirect PC, and keeps saturating performance counters.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_btb.sv | 58 +++++
 rtl/branch_predictor.sv | 138 +++++++++++++
 tb/tb_branch_predictor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter states, BTB entry layout
// and the saturating counter step.
package bp_pkg;

    localparam int BP_XLEN  = 32;
    // Sized for the smallest legal BTB (2 entries); narrower tags are zero-extended.
    localparam int BP_TAG_W = BP_XLEN - 3;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_cnt_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
    } bp_btb_entry_t;

    function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t nxt;
        nxt = cnt;
        if (taken && cnt != STRONG_T) begin
            nxt = bp_cnt_t'(cnt + 2'd1);
        end else if (!taken && cnt != STRONG_NT) begin
            nxt = bp_cnt_t'(cnt - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational tag-checked read, write at clk edge.
// A write is visible to reads from the following cycle; a same-cycle read sees the old entry.
module bp_btb
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    bp_btb_entry_t btb_q [BTB_ENTRIES];
    bp_btb_entry_t btb_d [BTB_ENTRIES];
    bp_btb_entry_t rd_entry;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_pc_bits;

    assign rd_idx         = rd_pc[IDX_W+1:2];
    assign wr_idx         = wr_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    always_comb begin
        rd_entry  = btb_q[rd_idx];
        rd_hit    = rd_entry.valid && (rd_entry.tag == BP_TAG_W'(rd_pc[XLEN-1:IDX_W+2]));
        rd_target = XLEN'(rd_entry.target);
    end

    always_comb begin
        btb_d = btb_q;
        if (wr_en) begin
            btb_d[wr_idx] = '{valid:  1'b1,
                              tag:    BP_TAG_W'(wr_pc[XLEN-1:IDX_W+2]),
                              target: BP_XLEN'(wr_target)};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal (or gshare when BP_GSHARE_EN is defined) direction table plus BTB; lookup and
// mispredict/redirect are combinational, training and saturating stats commit at clk edge.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int GHR_WIDTH   = 6
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic [XLEN-1:0]                if_pc,
    output logic                           pred_taken,
    output logic [XLEN-1:0]                pred_target,
    output logic [$clog2(BHT_ENTRIES)-1:0] pred_idx,
    input  logic                           upd_valid,
    input  logic [XLEN-1:0]                upd_pc,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx,
    input  logic                           upd_pred_taken,
    input  logic [XLEN-1:0]                upd_pred_target,
    input  logic                           upd_taken,
    input  logic [XLEN-1:0]                upd_target,
    output logic                           mispredict,
    output logic [XLEN-1:0]                redirect_pc,
    output logic [31:0]                    stat_branches,
    output logic [31:0]                    stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bp_cnt_t bht_q [BHT_ENTRIES];
    bp_cnt_t bht_d [BHT_ENTRIES];
    bp_cnt_t pred_cnt;

    logic [IDX_W-1:0] pc_idx;
    logic             btb_hit;
    logic [XLEN-1:0]  btb_target;
    logic             miss_raw;
    logic [31:0]      stat_branches_q, stat_branches_d;
    logic [31:0]      stat_mispredicts_q, stat_mispredicts_d;

    assign pc_idx = if_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

    assign pred_idx = pc_idx ^ IDX_W'(ghr_q);

    // History shifts in resolved outcomes only; truncation drops the oldest bit.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = GHR_WIDTH'({ghr_q, upd_taken});
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic [GHR_WIDTH-1:0] unused_ghr;

    assign unused_ghr = '0;
    assign pred_idx   = pc_idx;
`endif

    bp_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .reset_b   (reset_b),
        .rd_pc     (if_pc),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (upd_valid && upd_taken),
        .wr_pc     (upd_pc),
        .wr_target (upd_target)
    );

    always_comb begin
        pred_cnt    = bht_q[pred_idx];
        pred_taken  = pred_cnt[1] && btb_hit;
        pred_target = btb_hit ? btb_target : if_pc + XLEN'(4);
    end

    // Outputs are held at their reset values while reset is asserted, even mid-update.
    always_comb begin
        miss_raw    = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target)));
        mispredict  = reset_b && miss_raw;
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
        end
    end

    always_comb begin
        bht_d = bht_q;
        if (upd_valid) begin
            bht_d[upd_idx] = bp_cnt_next(bht_q[upd_idx], upd_taken);
        end
    end

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_valid && stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= WEAK_NT;
            end
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            bht_q              <= bht_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset state, training, saturation, aliasing, redirect,
// stat saturation, mid-update reset and history-dependent indexing.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_idx;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .reset_b          (reset_b),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_idx         (pred_idx),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_idx          (upd_idx),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic pt,
                       input logic [31:0] ptg, input logic t, input logic [31:0] tg);
        upd_pc          = pc;
        upd_idx         = idx;
        upd_pred_taken  = pt;
        upd_pred_target = ptg;
        upd_taken       = t;
        upd_target      = tg;
        upd_valid       = 1'b1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_pt [4];
        exp_pt = '{1'b1, 1'b0, 1'b0, 1'b0};

        reset_b = 1'b0;
        if_pc = 32'h40;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_idx = '0;
        upd_pred_taken = 1'b0;
        upd_pred_target = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        #1;

        // Reset state
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h44);
        chk("rst_pred_idx", 32'(pred_idx), 32'd16);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_stat_br", stat_branches, 32'd0);
        chk("rst_stat_mp", stat_mispredicts, 32'd0);

        // First taken resolve, predicted not-taken
        upd(32'h40, 6'd16, 1'b0, 32'h44, 1'b1, 32'h20);
        chk("t1_mispredict", 32'(mispredict), 32'd1);
        chk("t1_redirect", redirect_pc, 32'h20);
        chk("t1_no_bypass", 32'(pred_taken), 32'd0);
        tick();
        chk("t1_pred_taken", 32'(pred_taken), 32'd1);
        chk("t1_pred_target", pred_target, 32'h20);
        chk("t1_stat_br", stat_branches, 32'd1);
        chk("t1_stat_mp", stat_mispredicts, 32'd1);

        // Correctly predicted taken: counter to 11
        upd(32'h40, 6'd16, 1'b1, 32'h20, 1'b1, 32'h20);
        chk("t2_mispredict", 32'(mispredict), 32'd0);
        chk("t2_redirect", redirect_pc, 32'h0);
        tick();
        chk("t2_stat_br", stat_branches, 32'd2);
        chk("t2_stat_mp", stat_mispredicts, 32'd1);

        // Four not-taken resolves from 11: 10, 01, 00, 00
        for (int i = 0; i < 4; i++) begin
            upd(32'h40, 6'd16, 1'b1, 32'h20, 1'b0, 32'h0);
            chk("nt_redirect", redirect_pc, 32'h44);
            tick();
            chk("nt_pred_taken", 32'(pred_taken), 32'(exp_pt[i]));
        end
        chk("nt_btb_kept", pred_target, 32'h20);
        chk("nt_stat_br", stat_branches, 32'd6);
        chk("nt_stat_mp", stat_mispredicts, 32'd5);

        // Retrain 00 -> 01 -> 10
        for (int i = 0; i < 2; i++) begin
            upd(32'h40, 6'd16, 1'b0, 32'h44, 1'b1, 32'h20);
            chk("rt_mispredict", 32'(mispredict), 32'd1);
            tick();
        end
        chk("rt_pred_taken", 32'(pred_taken), 32'd1);

        // Wrong target
        upd(32'h40, 6'd16, 1'b1, 32'h20, 1'b1, 32'h80);
        chk("tg_mispredict", 32'(mispredict), 32'd1);
        chk("tg_redirect", redirect_pc, 32'h80);
        tick();
        chk("tg_pred_target", pred_target, 32'h80);
        chk("tg_pred_taken", 32'(pred_taken), 32'd1);
        chk("tg_stat_br", stat_branches, 32'd9);
        chk("tg_stat_mp", stat_mispredicts, 32'd8);

        // Aliasing: train counter at 0x80's BHT index, BTB entry keeps 0x40's tag
        upd(32'h40, 6'd32, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("al_mispredict", 32'(mispredict), 32'd0);
        tick();
        if_pc = 32'h80;
        #1;
        chk("al_pred_idx", 32'(pred_idx), 32'd32);
        chk("al_pred_taken", 32'(pred_taken), 32'd0);
        chk("al_pred_target", pred_target, 32'h84);

        // Inputs ignored without upd_valid
        upd_pc = 32'h40;
        upd_idx = 6'd16;
        upd_pred_taken = 1'b0;
        upd_taken = 1'b1;
        upd_target = 32'h300;
        #1;
        chk("iv_mispredict", 32'(mispredict), 32'd0);
        chk("iv_redirect", redirect_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        if_pc = 32'h40;
        #1;
        chk("iv_stat_br", stat_branches, 32'd10);
        chk("iv_stat_mp", stat_mispredicts, 32'd8);
        chk("iv_btb_target", pred_target, 32'h80);

        // PC+4 wraps
        if_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_pred_target", pred_target, 32'h0);
        chk("wrap_pred_taken", 32'(pred_taken), 32'd0);

        // Stat saturation
        force dut.stat_branches_q = 32'hFFFF_FFFE;
        force dut.stat_mispredicts_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_branches_q;
        release dut.stat_mispredicts_q;
        upd(32'h100, 6'd5, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        chk("sat1_stat_br", stat_branches, 32'hFFFF_FFFF);
        chk("sat1_stat_mp", stat_mispredicts, 32'hFFFF_FFFF);
        upd(32'h100, 6'd5, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        chk("sat2_stat_br", stat_branches, 32'hFFFF_FFFF);
        chk("sat2_stat_mp", stat_mispredicts, 32'hFFFF_FFFF);

        // Reset asserted mid-update
        if_pc = 32'h40;
        upd(32'h40, 6'd16, 1'b0, 32'h44, 1'b1, 32'h20);
        chk("mr_pre_mispredict", 32'(mispredict), 32'd1);
        chk("mr_pre_pred_taken", 32'(pred_taken), 32'd1);
        #1;
        reset_b = 1'b0;
        #1;
        chk("mr_pred_taken", 32'(pred_taken), 32'd0);
        chk("mr_pred_target", pred_target, 32'h44);
        chk("mr_mispredict", 32'(mispredict), 32'd0);
        chk("mr_redirect", redirect_pc, 32'h0);
        chk("mr_stat_br", stat_branches, 32'd0);
        chk("mr_stat_mp", stat_mispredicts, 32'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        reset_b = 1'b1;
        #1;
        chk("mr_after_pred_taken", 32'(pred_taken), 32'd0);

        // History T,T then (after reset) NT,NT
        upd(32'h200, 6'd0, 1'b0, 32'h204, 1'b1, 32'h300);
        tick();
        upd(32'h200, 6'd0, 1'b0, 32'h204, 1'b1, 32'h300);
        tick();
        if_pc = 32'h40;
        #1;
`ifdef BP_GSHARE_EN
        chk("hist_tt_idx", 32'(pred_idx), 32'd19);
`else
        chk("hist_tt_idx", 32'(pred_idx), 32'd16);
`endif
        reset_b = 1'b0;
        #1;
        reset_b = 1'b1;
        upd(32'h200, 6'd0, 1'b0, 32'h204, 1'b0, 32'h0);
        tick();
        upd(32'h200, 6'd0, 1'b0, 32'h204, 1'b0, 32'h0);
        tick();
        chk("hist_nn_idx", 32'(pred_idx), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
